// File: rtl/uart_tfifo_gen.sv
// uart_tfifo_gen: single-clock show-ahead FIFO for a UART transmit path.
// Provides occupancy count, threshold flags and sticky overrun/underrun
// error flags. Define UART_TFIFO_PEAK_EN to add the `peak` high-water
// mark output and its register.
module uart_tfifo_gen #(
  parameter int FIFO_WIDTH     = 8,
  parameter int FIFO_POINTER_W = 4,
  parameter int AF_LEVEL       = 12,
  parameter int AE_LEVEL       = 2
) (
  input  logic                      clk,
  input  logic                      fifo_reset,
  input  logic                      push,
  input  logic                      pop,
  input  logic [FIFO_WIDTH-1:0]     data_in,
  input  logic                      reset_status,
  output logic [FIFO_WIDTH-1:0]     data_out,
  output logic [FIFO_POINTER_W:0]   count,
  output logic                      full,
  output logic                      empty,
  output logic                      almost_full,
  output logic                      almost_empty,
  output logic                      overrun,
  output logic                      underrun
`ifdef UART_TFIFO_PEAK_EN
  ,
  output logic [FIFO_POINTER_W:0]   peak
`endif
);

  localparam int DEPTH = 2 ** FIFO_POINTER_W;
  localparam int CW    = FIFO_POINTER_W + 1;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

  // Storage is never reset; only the pointers/count define validity.
  logic [FIFO_WIDTH-1:0]     mem_q [DEPTH];

  logic [FIFO_POINTER_W-1:0] top_q, top_d;
  logic [FIFO_POINTER_W-1:0] bottom_q, bottom_d;
  logic [CW-1:0]             count_q, count_d;
  logic                      overrun_q, overrun_d;
  logic                      underrun_q, underrun_d;

  logic                      full_w;
  logic                      empty_w;
  logic                      do_push;
  logic                      do_pop;

  // Flags follow the registered count directly.
  assign full_w       = (count_q == DEPTH_C);
  assign empty_w      = (count_q == '0);
  assign full         = full_w;
  assign empty        = empty_w;
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);
  assign count        = count_q;
  assign overrun      = overrun_q;
  assign underrun     = underrun_q;
  assign data_out     = mem_q[bottom_q];

  // A push into a full FIFO is accepted only when a pop frees the head
  // slot in the same cycle; a pop of an empty FIFO is always ignored.
  assign do_push = push & (~full_w | pop);
  assign do_pop  = pop & ~empty_w;

  // Next-state for pointers, occupancy and sticky error flags.
  always_comb begin
    top_d      = top_q;
    bottom_d   = bottom_q;
    count_d    = count_q;
    overrun_d  = overrun_q;
    underrun_d = underrun_q;

    if (do_push) top_d    = top_q + 1'b1;
    if (do_pop)  bottom_d = bottom_q + 1'b1;

    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (push && full_w && !pop) overrun_d  = 1'b1;
    if (pop && empty_w)         underrun_d = 1'b1;

    // Clearing takes priority over an error raised in the same cycle.
    if (reset_status) begin
      overrun_d  = 1'b0;
      underrun_d = 1'b0;
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (fifo_reset) begin
      top_q      <= '0;
      bottom_q   <= '0;
      count_q    <= '0;
      overrun_q  <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      top_q      <= top_d;
      bottom_q   <= bottom_d;
      count_q    <= count_d;
      overrun_q  <= overrun_d;
      underrun_q <= underrun_d;
    end
  end

  // Storage write on accepted push; reset blocks the write.
  always_ff @(posedge clk) begin
    if (do_push && !fifo_reset) mem_q[top_q] <= data_in;
  end

`ifdef UART_TFIFO_PEAK_EN
  logic [CW-1:0] peak_q, peak_d;

  assign peak = peak_q;

  // High-water mark tracks the count that is about to be registered.
  always_comb begin
    peak_d = peak_q;
    if (count_d > peak_q) peak_d = count_d;
  end

  // Peak register, cleared only by fifo_reset.
  always_ff @(posedge clk) begin
    if (fifo_reset) peak_q <= '0;
    else            peak_q <= peak_d;
  end
`endif

endmodule

// File: tb/tb_uart_tfifo_gen.sv
// Testbench for uart_tfifo_gen: default-parameter instance driven by
// directed and random traffic against a queue-based reference model, plus
// a small 16-bit/depth-8 instance for the narrow-depth overrun case.
module tb_uart_tfifo_gen;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- default instance ----------------
  logic       fifo_reset, push, pop, reset_status;
  logic [7:0] data_in, data_out;
  logic [4:0] count;
  logic       full, empty, almost_full, almost_empty, overrun, underrun;
`ifdef UART_TFIFO_PEAK_EN
  logic [4:0] peak;
`endif

  uart_tfifo_gen u_dut (
    .clk(clk), .fifo_reset(fifo_reset), .push(push), .pop(pop),
    .data_in(data_in), .reset_status(reset_status), .data_out(data_out),
    .count(count), .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .overrun(overrun), .underrun(underrun)
`ifdef UART_TFIFO_PEAK_EN
    , .peak(peak)
`endif
  );

  // ---------------- small instance (16-bit, depth 8) ----------------
  logic        s_reset, s_push, s_pop, s_rs;
  logic [15:0] s_din, s_dout;
  logic [3:0]  s_count;
  logic        s_full, s_empty, s_af, s_ae, s_ovr, s_und;
`ifdef UART_TFIFO_PEAK_EN
  logic [3:0]  s_peak;
`endif

  uart_tfifo_gen #(.FIFO_WIDTH(16), .FIFO_POINTER_W(3), .AF_LEVEL(6), .AE_LEVEL(1)) u_small (
    .clk(clk), .fifo_reset(s_reset), .push(s_push), .pop(s_pop),
    .data_in(s_din), .reset_status(s_rs), .data_out(s_dout),
    .count(s_count), .full(s_full), .empty(s_empty), .almost_full(s_af),
    .almost_empty(s_ae), .overrun(s_ovr), .underrun(s_und)
`ifdef UART_TFIFO_PEAK_EN
    , .peak(s_peak)
`endif
  );

  // ---------------- scoreboard / reference model ----------------
  localparam int DEPTH = 16;
  logic [7:0] exp_q[$];
  bit         m_ovr, m_und;
  int         m_peak;
  int         checks   = 0;
  int         failures = 0;

  // Expected {full, empty, almost_full, almost_empty, overrun, underrun}.
  function automatic logic [5:0] exp_flags();
    int n;
    n = exp_q.size();
    return {n == DEPTH, n == 0, n >= 12, n <= 2, m_ovr, m_und};
  endfunction

  // Driver: apply one cycle of inputs, then advance the reference model.
  task automatic apply(input bit p, input bit o, input logic [7:0] d,
                       input bit rs, input bit rst);
    bit ovr_ev, und_ev;
    push = p; pop = o; data_in = d; reset_status = rs; fifo_reset = rst;
    @(posedge clk);
    #1;
    ovr_ev = 1'b0;
    und_ev = 1'b0;
    if (rst) begin
      exp_q.delete();
      m_ovr  = 1'b0;
      m_und  = 1'b0;
      m_peak = 0;
    end else begin
      if (p && o) begin
        if (exp_q.size() == 0) begin
          und_ev = 1'b1;
          exp_q.push_back(d);
        end else begin
          void'(exp_q.pop_front());
          exp_q.push_back(d);
        end
      end else if (p) begin
        if (exp_q.size() == DEPTH) ovr_ev = 1'b1;
        else                       exp_q.push_back(d);
      end else if (o) begin
        if (exp_q.size() == 0) und_ev = 1'b1;
        else                   void'(exp_q.pop_front());
      end
      if (rs) begin
        m_ovr = 1'b0;
        m_und = 1'b0;
      end else begin
        m_ovr = m_ovr | ovr_ev;
        m_und = m_und | und_ev;
      end
      if (exp_q.size() > m_peak) m_peak = exp_q.size();
    end
    push = 1'b0; pop = 1'b0; reset_status = 1'b0; fifo_reset = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    apply(0, 0, 8'h00, 0, 1);
    checks++;
    if (count !== 5'd0) begin
      failures++; $display("FAIL reset_count got=%0d exp=0", count);
    end
    checks++;
    if ({full, empty, almost_full, almost_empty, overrun, underrun} !== 6'b010100) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=010100",
               {full, empty, almost_full, almost_empty, overrun, underrun});
    end
  endtask

  task automatic test_fill_drain();
    logic [7:0] exp_d;
    for (int i = 0; i < 15; i++) begin
      apply(1, 0, 8'(8'h11 + i), 0, 0);
      checks++;
      if (count !== 5'(i + 1) || almost_full !== ((i + 1) >= 12)) begin
        failures++;
        $display("FAIL fill_count_af i=%0d got=%0d/%b exp=%0d/%b",
                 i, count, almost_full, i + 1, (i + 1) >= 12);
      end
    end
    for (int i = 0; i < 15; i++) begin
      exp_d = 8'(8'h11 + i);
      checks++;
      if (data_out !== exp_d) begin
        failures++; $display("FAIL drain_data i=%0d got=%h exp=%h", i, data_out, exp_d);
      end
      apply(0, 1, 8'h00, 0, 0);
    end
    checks++;
    if (empty !== 1'b1 || count !== 5'd0) begin
      failures++; $display("FAIL drain_empty got=%b/%0d exp=1/0", empty, count);
    end
  endtask

  task automatic test_overrun();
    apply(0, 0, 8'h00, 0, 1);
    for (int i = 0; i < 16; i++) apply(1, 0, 8'($urandom_range(0, 8'hA9)), 0, 0);
    apply(1, 0, 8'hAA, 0, 0);
    checks++;
    if (count !== 5'd16 || overrun !== 1'b1 || full !== 1'b1) begin
      failures++;
      $display("FAIL overrun_set got=%0d/%b/%b exp=16/1/1", count, overrun, full);
    end
    apply(0, 0, 8'h00, 1, 0);
    checks++;
    if (overrun !== 1'b0 || count !== 5'd16) begin
      failures++; $display("FAIL overrun_clear got=%b/%0d exp=0/16", overrun, count);
    end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (data_out === 8'hAA || data_out !== exp_q[0]) begin
        failures++; $display("FAIL overrun_drain i=%0d got=%h exp=%h", i, data_out, exp_q[0]);
      end
      apply(0, 1, 8'h00, 0, 0);
    end
  endtask

  task automatic test_pushpop_empty();
    apply(0, 0, 8'h00, 0, 1);
    apply(1, 1, 8'h5C, 0, 0);
    checks++;
    if (count !== 5'd1 || underrun !== 1'b1 || data_out !== 8'h5C) begin
      failures++;
      $display("FAIL pushpop_empty got=%0d/%b/%h exp=1/1/5c", count, underrun, data_out);
    end
  endtask

  task automatic test_pushpop_full();
    apply(0, 0, 8'h00, 0, 1);
    for (int i = 0; i < 16; i++) apply(1, 0, 8'($urandom), 0, 0);
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (data_out !== exp_q[0]) begin
        failures++; $display("FAIL full_pp_data i=%0d got=%h exp=%h", i, data_out, exp_q[0]);
      end
      apply(1, 1, 8'h77, 0, 0);
      checks++;
      if (count !== 5'd16 || overrun !== 1'b0) begin
        failures++; $display("FAIL full_pp_state i=%0d got=%0d/%b exp=16/0", i, count, overrun);
      end
    end
  endtask

  task automatic test_clear_wins();
    apply(0, 0, 8'h00, 0, 1);
    apply(0, 1, 8'h00, 1, 0);
    checks++;
    if (underrun !== 1'b0) begin
      failures++; $display("FAIL clear_wins got=%b exp=0", underrun);
    end
  endtask

  task automatic test_reset_midstream();
    apply(0, 0, 8'h00, 0, 1);
    for (int i = 0; i < 9; i++) apply(1, 0, 8'($urandom), 0, 0);
`ifdef UART_TFIFO_PEAK_EN
    checks++;
    if (peak !== 5'(m_peak)) begin
      failures++; $display("FAIL peak_before got=%0d exp=%0d", peak, m_peak);
    end
`endif
    apply(1, 1, 8'hE1, 1, 1);
    checks++;
    if (count !== 5'd0 || empty !== 1'b1 || full !== 1'b0 || almost_full !== 1'b0 ||
        overrun !== 1'b0 || underrun !== 1'b0) begin
      failures++; $display("FAIL midreset got count=%0d empty=%b exp 0/1", count, empty);
    end
`ifdef UART_TFIFO_PEAK_EN
    checks++;
    if (peak !== 5'd0) begin
      failures++; $display("FAIL peak_after got=%0d exp=0", peak);
    end
`endif
    apply(1, 0, 8'h3D, 0, 0);
    checks++;
    if (data_out !== 8'h3D || count !== 5'd1) begin
      failures++; $display("FAIL post_reset_push got=%h/%0d exp=3d/1", data_out, count);
    end
  endtask

  task automatic test_random();
    bit p, o, rs, rst;
    logic [7:0] d;
    apply(0, 0, 8'h00, 0, 1);
    for (int c = 0; c < 600; c++) begin
      // Bias toward pushes in the first half, pops in the second half.
      p   = ($urandom_range(0, 99) < ((c < 300) ? 70 : 35));
      o   = ($urandom_range(0, 99) < ((c < 300) ? 35 : 70));
      rs  = ($urandom_range(0, 99) < 5);
      rst = ($urandom_range(0, 299) == 0);
      d   = 8'($urandom);
      apply(p, o, d, rs, rst);
      checks++;
      if (count !== 5'(exp_q.size())) begin
        failures++; $display("FAIL rand_count c=%0d got=%0d exp=%0d", c, count, exp_q.size());
      end
      checks++;
      if ({full, empty, almost_full, almost_empty, overrun, underrun} !== exp_flags()) begin
        failures++;
        $display("FAIL rand_flags c=%0d got=%b exp=%b", c,
                 {full, empty, almost_full, almost_empty, overrun, underrun}, exp_flags());
      end
      if (exp_q.size() != 0) begin
        checks++;
        if (data_out !== exp_q[0]) begin
          failures++; $display("FAIL rand_data c=%0d got=%h exp=%h", c, data_out, exp_q[0]);
        end
      end
`ifdef UART_TFIFO_PEAK_EN
      checks++;
      if (peak !== 5'(m_peak)) begin
        failures++; $display("FAIL rand_peak c=%0d got=%0d exp=%0d", c, peak, m_peak);
      end
`endif
    end
  endtask

  task automatic test_small_config();
    s_reset = 1'b1;
    @(posedge clk); #1;
    s_reset = 1'b0;
    s_push  = 1'b1;
    s_din   = 16'hBEEF;
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
    end
    s_push = 1'b0;
    checks++;
    if (s_count !== 4'd8 || s_full !== 1'b1 || s_ovr !== 1'b1 || s_dout !== 16'hBEEF) begin
      failures++;
      $display("FAIL small_overrun got=%0d/%b/%b/%h exp=8/1/1/beef", s_count, s_full, s_ovr, s_dout);
    end
  endtask

  // ---------------- main sequence / final report ----------------
  initial begin
    fifo_reset = 1'b1; push = 1'b0; pop = 1'b0; reset_status = 1'b0; data_in = '0;
    s_reset = 1'b1; s_push = 1'b0; s_pop = 1'b0; s_rs = 1'b0; s_din = '0;
    m_ovr = 1'b0; m_und = 1'b0; m_peak = 0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_fill_drain();
    test_overrun();
    test_pushpop_empty();
    test_pushpop_full();
    test_clear_wins();
    test_reset_midstream();
    test_random();
    test_small_config();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
